// File: rtl/line2d_rasterizer.sv
// Bresenham line rasterizer: accepts one segment, streams every integer point on it.
// Optional LINE2D_POINT_INDEX_EN adds a pt_index output carrying each point's ordinal.
module line2d_rasterizer #(
  parameter int COORD_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_valid,
  output logic               line_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               pt_valid,
  input  logic               pt_ready,
  output logic [COORD_W-1:0] pt_x,
  output logic [COORD_W-1:0] pt_y,
  output logic               pt_last,
  output logic               busy
`ifdef LINE2D_POINT_INDEX_EN
  ,
  output logic [COORD_W:0]   pt_index
`endif
);

  localparam int EW = COORD_W + 2;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and its payload stable until that edge.
  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;
  state_t state, state_nxt;

  logic [COORD_W-1:0]  sx0, sy0, ex, ey, cur_x, cur_y, abs_x, abs_y;
  logic signed [EW-1:0] dx, dy, err, err_nxt;
  logic signed [EW:0]   e2, dx_ext, dy_ext;
  logic                 sx_neg, sy_neg, step_x, step_y, pt_fire, at_end;

  assign line_ready = (state == IDLE);
  assign pt_valid   = (state == DRAW);
  assign busy       = (state != IDLE);
  assign pt_x       = cur_x;
  assign pt_y       = cur_y;
  assign at_end     = (cur_x == ex) && (cur_y == ey);
  assign pt_last    = pt_valid && at_end;
  assign pt_fire    = pt_valid && pt_ready;

  assign abs_x  = (sx0 < ex) ? (ex - sx0) : (sx0 - ex);
  assign abs_y  = (sy0 < ey) ? (ey - sy0) : (sy0 - ey);
  assign e2     = {err, 1'b0};
  assign dx_ext = {dx[EW-1], dx};
  assign dy_ext = {dy[EW-1], dy};
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);

  // Both error updates use the same e2, so they may apply in one step.
  always_comb begin
    err_nxt = err;
    if (step_x) err_nxt = err_nxt + dy;
    if (step_y) err_nxt = err_nxt + dx;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_valid) state_nxt = SETUP;
      SETUP:   state_nxt = DRAW;
      DRAW:    if (pt_fire && at_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx0    <= '0;
      sy0    <= '0;
      ex     <= '0;
      ey     <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (line_valid) begin
            sx0 <= x0;
            sy0 <= y0;
            ex  <= x1;
            ey  <= y1;
          end
        end
        SETUP: begin
          dx     <= $signed({2'b00, abs_x});
          dy     <= -$signed({2'b00, abs_y});
          err    <= $signed({2'b00, abs_x}) - $signed({2'b00, abs_y});
          sx_neg <= !(sx0 < ex);
          sy_neg <= !(sy0 < ey);
          cur_x  <= sx0;
          cur_y  <= sy0;
        end
        DRAW: begin
          // Stalled points keep position and error untouched.
          if (pt_fire && !at_end) begin
            err <= err_nxt;
            if (step_x) cur_x <= sx_neg ? cur_x - COORD_W'(1) : cur_x + COORD_W'(1);
            if (step_y) cur_y <= sy_neg ? cur_y - COORD_W'(1) : cur_y + COORD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LINE2D_POINT_INDEX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pt_index <= '0;
    else if (state == SETUP) pt_index <= '0;
    else if (pt_fire)        pt_index <= pt_index + (COORD_W+1)'(1);
  end
`endif

endmodule

// File: tb/tb_line2d_rasterizer.sv
// Directed bench for line2d_rasterizer: hand-computed point lists, latency,
// backpressure, extreme endpoints and mid-line reset.
module tb_line2d_rasterizer;
  localparam int W  = 12;
  localparam int PW = 2 * W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         line_valid = 1'b0;
  logic         pt_ready = 1'b1;
  logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic         line_ready, pt_valid, pt_last, busy;
  logic [W-1:0] pt_x, pt_y;
`ifdef LINE2D_POINT_INDEX_EN
  logic [W:0]   pt_index;
  logic [W:0]   idx_q[$];
`endif

  line2d_rasterizer #(.COORD_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .line_valid(line_valid), .line_ready(line_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last), .busy(busy)
`ifdef LINE2D_POINT_INDEX_EN
    , .pt_index(pt_index)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // scoreboard: expected and observed points packed as {last, x, y}
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] obs_q[$];
  int            obs_c[$];
  int            checks = 0, failures = 0;
  int            hs_cyc = 0, ready_cyc = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && pt_valid && pt_ready) begin
      obs_q.push_back({pt_last, pt_x, pt_y});
      obs_c.push_back(cyc);
`ifdef LINE2D_POINT_INDEX_EN
      idx_q.push_back(pt_index);
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void exp_pt(input int x, input int y, input bit last);
    exp_q.push_back({last, W'(x), W'(y)});
  endfunction

  // driver tasks
  task automatic send_line(input int ax0, input int ay0, input int ax1, input int ay1);
    bit got = 1'b0;
    @(posedge clk); #1;
    line_valid = 1'b1;
    x0 = W'(ax0); y0 = W'(ay0); x1 = W'(ax1); y1 = W'(ay1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (line_ready) begin got = 1'b1; break; end
    end
    check("line_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    hs_cyc = cyc;
    line_valid = 1'b0;
    x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
  endtask

  task automatic wait_idle(input int limit);
    bit done = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      else if (line_ready) begin done = 1'b1; ready_cyc = cyc; break; end
    end
    check("line_done", 32'(done), 32'd1);
  endtask

  task automatic compare(input string tag, input bit timed);
    int n = exp_q.size();
    check({tag, "_count"}, 32'(obs_q.size()), 32'(n));
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      check($sformatf("%s_pt%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
`ifdef LINE2D_POINT_INDEX_EN
      check($sformatf("%s_idx%0d", tag, i), 32'(idx_q[i]), 32'(i));
`endif
    end
    if (timed && obs_q.size() > 0) begin
      check({tag, "_latency"}, 32'(obs_c[0] - hs_cyc), 32'd1);
      check({tag, "_span"}, 32'(obs_c[obs_c.size()-1] - obs_c[0]), 32'(n - 1));
      check({tag, "_ready_back"}, 32'(ready_cyc - obs_c[obs_c.size()-1]), 32'd1);
    end
    exp_q.delete();
    obs_q.delete();
    obs_c.delete();
`ifdef LINE2D_POINT_INDEX_EN
    idx_q.delete();
`endif
  endtask

  initial begin
    bit hit;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_line_ready", 32'(line_ready), 32'd1);
    check("rst_pt_valid", 32'(pt_valid), 32'd0);
    check("rst_pt_x", 32'(pt_x), 32'd0);
    check("rst_pt_y", 32'(pt_y), 32'd0);
    check("rst_pt_last", 32'(pt_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // horizontal
    exp_pt(0, 0, 0); exp_pt(1, 0, 0); exp_pt(2, 0, 0); exp_pt(3, 0, 1);
    send_line(0, 0, 3, 0);
    wait_idle(100);
    compare("horiz", 1'b1);

    // steep, forward and reverse
    exp_pt(3, 4, 0); exp_pt(4, 5, 0); exp_pt(5, 6, 0); exp_pt(5, 7, 0); exp_pt(6, 8, 1);
    send_line(3, 4, 6, 8);
    wait_idle(100);
    compare("steep_fwd", 1'b1);
    exp_pt(6, 8, 0); exp_pt(5, 7, 0); exp_pt(4, 6, 0); exp_pt(4, 5, 0); exp_pt(3, 4, 1);
    send_line(6, 8, 3, 4);
    wait_idle(100);
    compare("steep_rev", 1'b1);

    // degenerate: single point, busy for SETUP + one DRAW cycle
    exp_pt(7, 7, 1);
    send_line(7, 7, 7, 7);
    wait_idle(100);
    check("degen_busy_cycles", 32'(busy_cnt), 32'd2);
    compare("degen", 1'b1);

    // backpressure on the third point
    exp_pt(0, 0, 0); exp_pt(1, 0, 0); exp_pt(2, 1, 0);
    exp_pt(3, 1, 0); exp_pt(4, 2, 0); exp_pt(5, 2, 1);
    send_line(0, 0, 5, 2);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (obs_q.size() == 2) begin hit = 1'b1; break; end
    end
    check("bp_reach_third", 32'(hit), 32'd1);
    pt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), 32'(pt_valid), 32'd1);
      check($sformatf("bp_hold_pt%0d", i), 32'({pt_last, pt_x, pt_y}), 32'({1'b0, 12'd2, 12'd1}));
    end
    @(posedge clk); #1;
    pt_ready = 1'b1;
    wait_idle(100);
    compare("bp", 1'b0);

    // extremes: anti-diagonal, then a nearly flat full-width line
    for (int i = 0; i < 4096; i++) exp_pt(4095 - i, i, i == 4095);
    send_line(4095, 0, 0, 4095);
    wait_idle(5000);
    compare("anti_diag", 1'b1);
    for (int i = 0; i < 4096; i++) exp_pt(i, (i >= 2048) ? 1 : 0, i == 4095);
    send_line(0, 0, 4095, 1);
    wait_idle(5000);
    compare("flat_wide", 1'b1);

    // reset in the middle of a line
    send_line(0, 0, 9, 0);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (obs_q.size() == 4) begin hit = 1'b1; break; end
    end
    check("abort_reach_four", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_pt_valid", 32'(pt_valid), 32'd0);
    check("abort_line_ready", 32'(line_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    exp_pt(0, 0, 0); exp_pt(1, 0, 0); exp_pt(2, 0, 0); exp_pt(3, 0, 0);
    compare("abort_partial", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_leftover", 32'(obs_q.size()), 32'd0);
    exp_pt(2, 2, 0); exp_pt(2, 3, 0); exp_pt(2, 4, 1);
    send_line(2, 2, 2, 4);
    wait_idle(100);
    compare("after_abort", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
